wifi_rx_deinterleaver192: RTL and testbench

- Receive-path block-deinterleaver for the WIFI PHY.
- Takes hard-decision coded bits serially from the demapper and restores original coded-bit order per OFDM symbol. It undoes the TX two-stage interleave.
- First symbol of a frame is the 48-bit BPSK SIGNAL field; every following symbol is 192 bits, 16-QAM.
- Output feeds the Viterbi decoder serially, one bit per cycle. A two-bank ping-pong buffer lets symbol n+1 be written while symbol n is read.

---
 rtl/wifi_rx_deinterleaver192_if.sv | 21 ++
 rtl/wifi_rx_deinterleaver192.sv | 226 ++++++++++++++++++++++
 tb/tb_wifi_rx_deinterleaver192.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/wifi_rx_deinterleaver192_if.sv
// Serial coded-bit stream into the RX deinterleaver and deinterleaved stream out to the Viterbi decoder.
interface wifi_rx_deinterleaver192_if;
   logic enable;
   logic valid_in;
   logic data_in;
   logic last_in;
   logic valid_out;
   logic data_out;
   logic finished;
   logic err_len;

   modport master (
      output enable, valid_in, data_in, last_in,
      input  valid_out, data_out, finished, err_len
   );

   modport slave (
      input  enable, valid_in, data_in, last_in,
      output valid_out, data_out, finished, err_len
   );
endinterface

// File: rtl/wifi_rx_deinterleaver192.sv
// RX block deinterleaver: scatters air-order bits into a ping-pong bank, reads them out in coded order.
// Macro WIFI_RX_DEINTERLEAVER_SIGNAL_EN: symbol 0 of each frame is the 48-bit BPSK SIGNAL field.
module wifi_rx_deinterleaver192 #(
   parameter int NCBPS   = 192,
   parameter int NBPSC   = 4,
   parameter int NCBPS_S = 48,
   parameter int NBPSC_S = 1
) (
   input logic clk,
   input logic reset,
   wifi_rx_deinterleaver192_if.slave bus
);
   localparam int S_D = (NBPSC / 2 > 1) ? NBPSC / 2 : 1;
   localparam int S_S = (NBPSC_S / 2 > 1) ? NBPSC_S / 2 : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  wr_bank_q, wr_bank_d;
   logic [7:0]            jr_q, jr_d;   // offset of j inside its 16-way group
   logic [2:0]            jm_q, jm_d;   // j mod s
   logic [3:0]            g_q, g_d;     // floor(16j/N)
   logic [2:0]            gm_q, gm_d;   // g mod s
   logic [1:0]            full_q, full_d;
   logic [1:0][NCBPS-1:0] mem_q, mem_d;
   logic                  rd_active_q, rd_active_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [7:0]            rd_addr_q, rd_addr_d;
   logic                  valid_out_q, valid_out_d;
   logic                  data_out_q, data_out_d;
   logic                  finished_q, finished_d;
   logic                  err_len_q, err_len_d;

   logic                  sym_sig, rd_sig;

`ifdef WIFI_RX_DEINTERLEAVER_SIGNAL_EN
   logic                  first_q, first_d;
   logic [1:0]            len48_q, len48_d;
   assign sym_sig = first_q;
   assign rd_sig  = len48_q[rd_bank_q];
`else
   assign sym_sig = 1'b0;
   assign rd_sig  = 1'b0;
`endif

   logic [7:0] grp_m1, rd_len_m1, r, wr_addr;
   logic [2:0] s_cur, jm_inc, gm_inc;
   logic [3:0] sum, rot;
   logic       accept, sym_end;

   // Inside group g the address is k = 16*r + g, r being the group offset with
   // the per-group rotation of the s-bit subcarrier fields applied.
   always_comb begin
      grp_m1    = sym_sig ? 8'(NCBPS_S / 16 - 1) : 8'(NCBPS / 16 - 1);
      s_cur     = sym_sig ? 3'(S_S) : 3'(S_D);
      rd_len_m1 = rd_sig ? 8'(NCBPS_S - 1) : 8'(NCBPS - 1);
      sum       = {1'b0, jm_q} + {1'b0, gm_q};
      rot       = (sum >= {1'b0, s_cur}) ? sum - {1'b0, s_cur} : sum;
      r         = jr_q - {5'd0, jm_q} + {4'd0, rot};
      wr_addr   = (r << 4) | {4'd0, g_q};
      jm_inc    = (jm_q + 3'd1 == s_cur) ? 3'd0 : jm_q + 3'd1;
      gm_inc    = (gm_q + 3'd1 == s_cur) ? 3'd0 : gm_q + 3'd1;
      sym_end   = (g_q == 4'd15) && (jr_q == grp_m1);
      accept    = bus.valid_in && bus.enable && (state_q != ST_DRAIN);
   end

   always_comb begin
      state_d     = state_q;
      wr_bank_d   = wr_bank_q;
      jr_d        = jr_q;
      jm_d        = jm_q;
      g_d         = g_q;
      gm_d        = gm_q;
      full_d      = full_q;
      mem_d       = mem_q;
      rd_active_d = rd_active_q;
      rd_bank_d   = rd_bank_q;
      rd_addr_d   = rd_addr_q;
      valid_out_d = 1'b0;
      data_out_d  = data_out_q;
      finished_d  = finished_q;
      err_len_d   = 1'b0;
`ifdef WIFI_RX_DEINTERLEAVER_SIGNAL_EN
      first_d     = first_q;
      len48_d     = len48_q;
`endif

      // Read engine: banks strictly alternate, so the next bank is always the other one.
      if (rd_active_q) begin
         valid_out_d = 1'b1;
         data_out_d  = mem_q[rd_bank_q][rd_addr_q];
         if (rd_addr_q == rd_len_m1) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_addr_d         = 8'd0;
            rd_active_d       = full_q[~rd_bank_q];
         end else begin
            rd_addr_d = rd_addr_q + 8'd1;
         end
      end else if (full_q[rd_bank_q]) begin
         rd_active_d = 1'b1;
         rd_addr_d   = 8'd0;
      end

      if (accept) begin
         mem_d[wr_bank_q][wr_addr] = bus.data_in;
         if (state_q == ST_IDLE) begin
            state_d    = ST_FILL;
            finished_d = 1'b0;
         end
         if (sym_end) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
            jr_d              = 8'd0;
            jm_d              = 3'd0;
            g_d               = 4'd0;
            gm_d              = 3'd0;
`ifdef WIFI_RX_DEINTERLEAVER_SIGNAL_EN
            len48_d[wr_bank_q] = first_q;
            first_d            = 1'b0;
`endif
            if (bus.last_in) state_d = ST_DRAIN;
         end else if (bus.last_in) begin
            // Partial symbol: never marked full, so it is simply overwritten later.
            err_len_d = 1'b1;
            state_d   = ST_DRAIN;
            jr_d      = 8'd0;
            jm_d      = 3'd0;
            g_d       = 4'd0;
            gm_d      = 3'd0;
         end else if (jr_q == grp_m1) begin
            jr_d = 8'd0;
            jm_d = 3'd0;
            g_d  = g_q + 4'd1;
            gm_d = gm_inc;
         end else begin
            jr_d = jr_q + 8'd1;
            jm_d = jm_inc;
         end
      end

      if (state_q == ST_DRAIN && full_q == 2'b00 && !rd_active_q && !valid_out_q) begin
         state_d    = ST_IDLE;
         finished_d = 1'b1;
         wr_bank_d  = 1'b0;
         rd_bank_d  = 1'b0;
`ifdef WIFI_RX_DEINTERLEAVER_SIGNAL_EN
         first_d    = 1'b1;
`endif
      end

      if (!bus.enable && state_q != ST_IDLE) begin
         state_d     = ST_IDLE;
         full_d      = 2'b00;
         rd_active_d = 1'b0;
         rd_bank_d   = 1'b0;
         rd_addr_d   = 8'd0;
         wr_bank_d   = 1'b0;
         jr_d        = 8'd0;
         jm_d        = 3'd0;
         g_d         = 4'd0;
         gm_d        = 3'd0;
         valid_out_d = 1'b0;
         data_out_d  = 1'b0;
         finished_d  = 1'b1;
         err_len_d   = 1'b0;
`ifdef WIFI_RX_DEINTERLEAVER_SIGNAL_EN
         first_d     = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         wr_bank_q   <= 1'b0;
         jr_q        <= 8'd0;
         jm_q        <= 3'd0;
         g_q         <= 4'd0;
         gm_q        <= 3'd0;
         full_q      <= 2'b00;
         rd_active_q <= 1'b0;
         rd_bank_q   <= 1'b0;
         rd_addr_q   <= 8'd0;
         valid_out_q <= 1'b0;
         data_out_q  <= 1'b0;
         finished_q  <= 1'b1;
         err_len_q   <= 1'b0;
`ifdef WIFI_RX_DEINTERLEAVER_SIGNAL_EN
         first_q     <= 1'b1;
         len48_q     <= 2'b00;
`endif
      end else begin
         state_q     <= state_d;
         wr_bank_q   <= wr_bank_d;
         jr_q        <= jr_d;
         jm_q        <= jm_d;
         g_q         <= g_d;
         gm_q        <= gm_d;
         full_q      <= full_d;
         rd_active_q <= rd_active_d;
         rd_bank_q   <= rd_bank_d;
         rd_addr_q   <= rd_addr_d;
         valid_out_q <= valid_out_d;
         data_out_q  <= data_out_d;
         finished_q  <= finished_d;
         err_len_q   <= err_len_d;
`ifdef WIFI_RX_DEINTERLEAVER_SIGNAL_EN
         first_q     <= first_d;
         len48_q     <= len48_d;
`endif
      end
   end

   // Bank contents are only ever read behind a full flag, so they need no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign bus.valid_out = valid_out_q;
   assign bus.data_out  = data_out_q;
   assign bus.finished  = finished_q;
   assign bus.err_len   = err_len_q;
endmodule

// File: tb/tb_wifi_rx_deinterleaver192.sv
// Scoreboard bench for wifi_rx_deinterleaver192; expected bits come from the TX interleaver formula.
module tb_wifi_rx_deinterleaver192;
`ifdef WIFI_RX_DEINTERLEAVER_SIGNAL_EN
   localparam int N0 = 48;
`else
   localparam int N0 = 192;
`endif
   localparam int ND = 192;

   logic clk = 1'b0;
   logic reset = 1'b0;

   wifi_rx_deinterleaver192_if bus ();

   wifi_rx_deinterleaver192 dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int fall_cyc = 0;
   int bursts = 0;
   int err_cnt = 0;
   int t_last = 0;
   bit prev_v = 1'b0;
   bit exp_q[$];
   bit air[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every valid output bit must match the head of the expected queue.
   always @(posedge clk) begin
      #1;
      if (bus.valid_out === 1'b1) begin
         chk("out_expected", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) chk("data_out", int'(bus.data_out), int'(exp_q.pop_front()));
         if (!prev_v) bursts++;
      end
      if (prev_v && bus.valid_out !== 1'b1) fall_cyc = cyc;
      if (bus.err_len === 1'b1) err_cnt++;
      prev_v = (bus.valid_out === 1'b1);
   end

   // TX interleaver: coded index k is transmitted at air index j.
   function automatic int air_idx(input int k, input int n);
      int nbpsc, s, i;
      nbpsc = (n == 48) ? 1 : 4;
      s = (nbpsc / 2 > 1) ? nbpsc / 2 : 1;
      i = (n / 16) * (k % 16) + k / 16;
      return s * (i / s) + (i + n - (16 * i) / n) % s;
   endfunction

   task automatic push_model(input int base, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(air[base + air_idx(k, n)]);
   endtask

   task automatic gen_air(input int n);
      air.delete();
      for (int x = 0; x < n; x++) air.push_back(bit'($urandom_range(1, 0)));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input bit d, input bit last);
      bus.valid_in = 1'b1;
      bus.data_in  = d;
      bus.last_in  = last;
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      bus.data_in  = 1'b0;
      bus.last_in  = 1'b0;
      t_last = cyc;
   endtask

   task automatic send_air(input int from, input int last_idx, input int gap_max);
      for (int n = from; n < air.size(); n++) begin
         if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
         drive(air[n], n == last_idx);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (bus.finished !== 1'b1 && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_idle"}, int'(bus.finished === 1'b1), 1);
      chk({name, "_fin_rise"}, cyc - fall_cyc, 1);
      chk({name, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0, b0, lat, p1;
      bus.enable   = 1'b1;
      bus.valid_in = 1'b0;
      bus.data_in  = 1'b0;
      bus.last_in  = 1'b0;

      // Reset held for three cycles
      idle(3);
      chk("rst_valid_out", int'(bus.valid_out), 0);
      chk("rst_finished", int'(bus.finished), 1);
      chk("rst_err_len", int'(bus.err_len), 0);
      reset = 1'b1;
      idle(2);

      // First symbol alone, single one at air index 3
      air.delete();
      for (int x = 0; x < N0; x++) air.push_back(x == 3);
      p1 = (N0 == 48) ? 1 : 48;
      for (int k = 0; k < N0; k++) exp_q.push_back(k == p1);
      drive(air[0], 1'b0);
      chk("fin_fall", int'(bus.finished), 0);
      send_air(1, N0 - 1, 0);
      lat = -1;
      for (int w = 1; w <= 8 && lat < 0; w++) begin
         @(posedge clk);
         #1;
         if (bus.valid_out === 1'b1) lat = cyc - t_last;
      end
      chk("latency", lat, 2);
      wait_idle("sym0");
      idle(3);

      // Data symbol mapping with ones at air 1, 12, 13 -> coded 16, 17, 1
      air.delete();
      for (int x = 0; x < N0; x++) air.push_back(1'b0);
      for (int x = 0; x < ND; x++) air.push_back(x == 1 || x == 12 || x == 13);
      for (int k = 0; k < N0; k++) exp_q.push_back(1'b0);
      for (int k = 0; k < ND; k++) exp_q.push_back(k == 1 || k == 16 || k == 17);
      send_air(0, N0 + ND - 1, 0);
      wait_idle("map");
      idle(3);

      // Back-to-back random symbols at full rate
      gen_air(N0 + 3 * ND);
      push_model(0, N0);
      for (int m = 0; m < 3; m++) push_model(N0 + m * ND, ND);
      b0 = bursts;
      send_air(0, N0 + 3 * ND - 1, 0);
      wait_idle("b2b");
      chk("b2b_bursts", bursts - b0, (N0 == 48) ? 2 : 1);
      idle(3);

      // Random input gaps
      gen_air(N0 + 2 * ND);
      push_model(0, N0);
      push_model(N0, ND);
      push_model(N0 + ND, ND);
      send_air(0, N0 + 2 * ND - 1, 3);
      wait_idle("gaps");
      idle(3);

      // Short frame: last_in on bit 100 of the first data symbol
      gen_air(N0 + 101);
      push_model(0, N0);
      e0 = err_cnt;
      send_air(0, N0 + 100, 0);
      wait_idle("short");
      chk("short_err_pulses", err_cnt - e0, 1);
      idle(3);

      // Abort at data bit 50, then a clean frame
      gen_air(N0 + 50);
      push_model(0, N0);
      e0 = err_cnt;
      send_air(0, -1, 0);
      bus.enable = 1'b0;
      drive(1'b1, 1'b1);
      chk("abort_valid_out", int'(bus.valid_out), 0);
      chk("abort_finished", int'(bus.finished), 1);
      exp_q.delete();
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      chk("disabled_ignored", int'(bus.finished), 1);
      bus.enable = 1'b1;
      idle(5);
      chk("abort_quiet", int'(bus.valid_out), 0);
      chk("abort_no_err", err_cnt - e0, 0);
      gen_air(N0 + ND);
      push_model(0, N0);
      push_model(N0, ND);
      send_air(0, N0 + ND - 1, 0);
      wait_idle("post_abort");
      idle(3);

      // Reset in mid-frame while the first bank is draining
      gen_air(N0 + 20);
      push_model(0, N0);
      send_air(0, -1, 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      chk("mid_rst_valid_out", int'(bus.valid_out), 0);
      chk("mid_rst_finished", int'(bus.finished), 1);
      reset = 1'b1;
      idle(300);
      chk("mid_rst_quiet", int'(bus.valid_out), 0);

      chk("final_queue", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
